// File: rtl/serial_seq_pkg.sv
// Shared types and helpers for the serial sequencer.
package serial_seq_pkg;

    // Upper bound on pattern length supported by the sequencer.
    localparam int SEQ_MAX_WIDTH = 32;

    // Sequencer control states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Mask with the low n bits set; n at or above the maximum width gives all ones.
    function automatic logic [SEQ_MAX_WIDTH-1:0] low_mask(input int n);
        if (n >= SEQ_MAX_WIDTH)
            return '1;
        else
            return (SEQ_MAX_WIDTH'(1) << n) - SEQ_MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/serial_seq_cnt.sv
// Bit counter shared by the shift-out and capture indexing of the sequencer.
// cnt is the index of the pattern bit currently driven to the FSM; last flags
// the final bit of the run.
module serial_seq_cnt #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] cnt,
    output logic             last
);

    // Counter register: clear on a new run, advance while enabled.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + LEN_W'(1);
    end

    assign last = (cnt == len - LEN_W'(1));

endmodule

// File: rtl/serial_seq_ctrl.sv
// Serial-input FSM sequencer: accepts a pattern, resets the attached FSM for
// one cycle, shifts the pattern out LSB first and captures the Moore output
// one cycle behind each bit into an index-addressed response word.
// Optional build macro SERIAL_SEQ_COMPARE_EN adds an expected-response compare
// (ports expected, mismatch, err_cnt).
module serial_seq_ctrl
    import serial_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
`ifdef SERIAL_SEQ_COMPARE_EN
    input  logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic [7:0]       err_cnt,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resp,
    output logic             fsm_in,
    output logic             fsm_rst_n,
    input  logic             fsm_out
);

    seq_state_t       state;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] cap_idx;
    logic [WIDTH-1:0] resp_nxt;
    logic             last;
    logic             accept;
    logic             cnt_en;
    logic             next_bit;

    // Oversized requests are clamped to the register width.
    assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign accept  = start && ready;
    assign cnt_en  = (state == RUN) && !last;
    assign cnt_nxt = cnt + LEN_W'(1);
    // Pattern bit for the next RUN cycle; a mask test avoids an oversized index.
    assign next_bit = |(pat_q & (WIDTH'(1) << cnt_nxt));

    serial_seq_cnt #(
        .LEN_W (LEN_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (cnt_en),
        .len   (len_q),
        .cnt   (cnt),
        .last  (last)
    );

    // Next response word: cleared on accept, one bit written per capture.
    // The counter holds at len-1 during DRAIN, so DRAIN captures at cnt while
    // RUN captures the previous bit at cnt-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        resp_nxt = resp;
        cap_idx  = cnt;
        if (accept) begin
            resp_nxt = '0;
        end else if ((state == RUN && cnt != '0) || state == DRAIN) begin
            cap_idx  = (state == RUN) ? cnt - LEN_W'(1) : cnt;
            resp_nxt = (resp & ~(WIDTH'(1) << cap_idx))
                     | ({{(WIDTH-1){1'b0}}, fsm_out} << cap_idx);
        end
    end

    // Control FSM with registered handshake and FSM-drive outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resp      <= '0;
            fsm_in    <= 1'b0;
            fsm_rst_n <= 1'b0;
            pat_q     <= '0;
            len_q     <= '0;
        end else begin
            resp <= resp_nxt;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ready     <= 1'b1;
                    fsm_rst_n <= 1'b1;
                    fsm_in    <= 1'b0;
                    if (accept) begin
                        pat_q <= pattern;
                        len_q <= len_eff;
                        ready <= 1'b0;
                        if (len_eff == '0) begin
                            // Empty run: report completion with an all-zero response.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= CLR;
                            busy      <= 1'b1;
                            fsm_rst_n <= 1'b0;
                        end
                    end
                end
                CLR: begin
                    state     <= RUN;
                    fsm_rst_n <= 1'b1;
                    fsm_in    <= pat_q[0];
                end
                RUN: begin
                    if (last) begin
                        state  <= DRAIN;
                        fsm_in <= 1'b0;
                    end else begin
                        fsm_in <= next_bit;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SEQ_COMPARE_EN
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] len_mask;

    assign len_mask = WIDTH'(low_mask(int'(len_q)));

    // Compare the final response against the expected word when done is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q    <= '0;
            mismatch <= 1'b0;
            err_cnt  <= 8'd0;
        end else if (accept) begin
            exp_q    <= expected;
            mismatch <= 1'b0;
        end else if (state == DRAIN && |((resp_nxt ^ exp_q) & len_mask)) begin
            mismatch <= 1'b1;
            if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Bench for serial_seq_ctrl driving a 4-state Moore FSM
// (a:0 b:1 c:1 d:0; a -1-> b, a -0-> c, b -1-> d, b -0-> c,
//  c -1-> d, c -0-> a, d -1-> d, d -0-> b).
module tb_serial_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int LEN_W = $clog2(WIDTH + 1);

    typedef struct {
        logic [WIDTH-1:0] resp;
        int               lat;
        logic             mism;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [LEN_W-1:0] len = '0;
    logic             ready, busy, done;
    logic [WIDTH-1:0] resp;
    logic             fsm_in, fsm_rst_n, fsm_out;
`ifdef SERIAL_SEQ_COMPARE_EN
    logic [WIDTH-1:0] expected = '0;
    logic             mismatch;
    logic [7:0]       err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   rst_lo = 0;
    int   ones = 0;
    exp_t sb_q[$];
    int   acc_q[$];
    int   acc_log[$];
    exp_t mon_e;
    int   mon_a;

    always #5 clk = ~clk;

    serial_seq_ctrl #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
`ifdef SERIAL_SEQ_COMPARE_EN
        .expected  (expected),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .resp      (resp),
        .fsm_in    (fsm_in),
        .fsm_rst_n (fsm_rst_n),
        .fsm_out   (fsm_out)
    );

    // ---------------- attached Moore FSM and its reference model ----------
    function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd2;
            2'd1:    return b ? 2'd3 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd0;
            default: return b ? 2'd3 : 2'd1;
        endcase
    endfunction

    function automatic logic fsm_outf(input logic [1:0] s);
        return (s == 2'd1) || (s == 2'd2);
    endfunction

    logic [1:0] fsm_s;
    always @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) fsm_s <= 2'd0;
        else            fsm_s <= fsm_next(fsm_s, fsm_in);
    end
    assign fsm_out = fsm_outf(fsm_s);

    function automatic logic [WIDTH-1:0] model_resp(input logic [WIDTH-1:0] p, input int n);
        logic [1:0]       s = 2'd0;
        logic [WIDTH-1:0] r = '0;
        for (int k = 0; k < n; k++) begin
            s    = fsm_next(s, p[k]);
            r[k] = fsm_outf(s);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] len_mask(input int n);
        logic [WIDTH-1:0] m = '0;
        for (int k = 0; k < n; k++) m[k] = 1'b1;
        return m;
    endfunction

    // ---------------- monitor: samples pre-edge values at each rising edge --
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start && ready) begin
                acc_q.push_back(cyc);
                acc_log.push_back(cyc);
                accepts++;
            end
            if (!fsm_rst_n) rst_lo++;
            if (fsm_in) ones++;
            if (done) begin
                checks++;
                if (sb_q.size() == 0 || acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d with no run outstanding", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_a = acc_q.pop_front();
                    if (resp !== mon_e.resp) begin
                        errors++;
                        $display("FAIL resp: got %b required %b", resp, mon_e.resp);
                    end
                    checks++;
                    if (cyc - mon_a != mon_e.lat) begin
                        errors++;
                        $display("FAIL latency: got %0d required %0d", cyc - mon_a, mon_e.lat);
                    end
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_at_done: got %b required 0", busy);
                    end
`ifdef SERIAL_SEQ_COMPARE_EN
                    checks++;
                    if (mismatch !== mon_e.mism) begin
                        errors++;
                        $display("FAIL mismatch_at_done: got %b required %b", mismatch, mon_e.mism);
                    end
`endif
                end
            end
        end
    end

    // ---------------- stimulus helpers (enter and leave at a falling edge) --
    task automatic issue(input logic [WIDTH-1:0] p, input int l, input logic [WIDTH-1:0] ex);
        int   n = 0;
        int   le;
        exp_t e;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: ready=%b required 1", ready);
        end
        le     = (l > WIDTH) ? WIDTH : l;
        e.resp = model_resp(p, le);
        e.lat  = (le == 0) ? 1 : le + 3;
        e.mism = |((e.resp ^ ex) & len_mask(le));
        sb_q.push_back(e);
        pattern = p;
        len     = LEN_W'(l);
`ifdef SERIAL_SEQ_COMPARE_EN
        expected = ex;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || ready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: %0d runs still outstanding", sb_q.size());
        end
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ready, busy, done, fsm_rst_n, fsm_in} !== 5'b0 || resp !== '0) begin
                errors++;
                $display("FAIL reset_values: rdy=%b busy=%b done=%b frst=%b fin=%b resp=%b required all 0",
                         ready, busy, done, fsm_rst_n, fsm_in, resp);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || fsm_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b fsm_rst_n=%b required 1 1", ready, fsm_rst_n);
        end
    endtask

    task automatic test_directed();
        logic [3:0] bits = 4'b0101;
        int         lo0  = rst_lo;
        issue(8'b0000_0101, 4, 8'h00);
        checks++;
        if (fsm_rst_n !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_cycle: frst=%b busy=%b ready=%b required 0 1 0", fsm_rst_n, busy, ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (fsm_in !== bits[k] || fsm_rst_n !== 1'b1) begin
                errors++;
                $display("FAIL run_bit%0d: fsm_in=%b fsm_rst_n=%b required %b 1", k, fsm_in, fsm_rst_n, bits[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (fsm_in !== 1'b0) begin
            errors++;
            $display("FAIL drain_in: got %b required 0", fsm_in);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || resp !== 8'b0000_1011) begin
            errors++;
            $display("FAIL directed_done: done=%b resp=%b required 1 00001011", done, resp);
        end
        wait_idle();
        checks++;
        if (rst_lo - lo0 != 1) begin
            errors++;
            $display("FAIL fsm_rst_pulse: got %0d low cycles required 1", rst_lo - lo0);
        end
    endtask

    task automatic test_back_to_back();
        int n0 = acc_log.size();
        issue(8'b0000_0111, 3, 8'h00);
        issue(8'b0000_0101, 4, 8'h00);
        wait_idle();
        checks++;
        if (acc_log.size() - n0 != 2) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 2", acc_log.size() - n0);
        end else if (acc_log[n0 + 1] - acc_log[n0] != 7) begin
            errors++;
            $display("FAIL b2b_period: got %0d required 7", acc_log[n0 + 1] - acc_log[n0]);
        end
    endtask

    task automatic test_len_zero();
        int lo0 = rst_lo;
        int on0 = ones;
        issue(8'hA5, 0, 8'h00);
        wait_idle();
        checks++;
        if (rst_lo != lo0 || ones != on0) begin
            errors++;
            $display("FAIL len0_activity: rst_low=%0d ones=%0d required 0 0", rst_lo - lo0, ones - on0);
        end
    endtask

    task automatic test_clamp();
        int on0 = ones;
        issue(8'hFF, 9, 8'h00);
        wait_idle();
        checks++;
        if (ones - on0 != 8) begin
            errors++;
            $display("FAIL clamp_run_cycles: got %0d required 8", ones - on0);
        end
    endtask

    task automatic test_held_start();
        int   a0 = accepts;
        exp_t e;
        @(negedge clk);
        e.resp = model_resp(8'b0000_0011, 2);
        e.lat  = 5;
        e.mism = |e.resp;
        sb_q.push_back(e);
        sb_q.push_back(e);
        pattern = 8'b0000_0011;
        len     = LEN_W'(2);
`ifdef SERIAL_SEQ_COMPARE_EN
        expected = 8'h00;
`endif
        start = 1'b1;
        repeat (7) @(negedge clk);
        start = 1'b0;
        wait_idle();
        checks++;
        if (accepts - a0 != 2) begin
            errors++;
            $display("FAIL held_start_accepts: got %0d required 2", accepts - a0);
        end
    endtask

    task automatic test_reset_mid_run();
        issue(8'hFF, 8, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (resp !== 8'b0000_0001) begin
            errors++;
            $display("FAIL partial_resp: got %b required 00000001", resp);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || resp !== '0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_values: busy=%b done=%b resp=%b ready=%b required 0 0 0 0",
                     busy, done, resp, ready);
        end
        sb_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b required 1", ready);
        end
        repeat (12) @(negedge clk);
    endtask

`ifdef SERIAL_SEQ_COMPARE_EN
    task automatic test_compare();
        issue(8'b0000_0101, 4, 8'b0000_1011);
        wait_idle();
        checks++;
        if (mismatch !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL compare_match: mismatch=%b err_cnt=%0d required 0 0", mismatch, err_cnt);
        end
        issue(8'b0000_0101, 4, 8'b0000_1111);
        wait_idle();
        checks++;
        if (mismatch !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL compare_miss: mismatch=%b err_cnt=%0d required 1 1", mismatch, err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_len_zero();
        test_clamp();
        test_held_start();
        test_reset_mid_run();
`ifdef SERIAL_SEQ_COMPARE_EN
        test_compare();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/serial_seq_ctrl.md
# serial_seq_ctrl

Sequencer that drives a serial-input finite state machine: accepts a bit pattern through a start handshake, resets the attached FSM, and shifts the pattern into its serial input one bit per clock, LSB first. It captures the FSM's Moore output into a response word and signals completion. It sits between the test/control logic and one single-bit FSM instance, such as the 4-state Moore/Mealy machines, and owns that FSM's `in` and `rst_n`.

## Interface
- WIDTH, 8, maximum pattern length in bits (2..32)
- LEN_W, $clog2(WIDTH+1), width of `len`
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a run; accepted only when `ready`=1
- pattern  input  WIDTH  bits to shift out, bit 0 first; sampled on accept
- len  input  LEN_W  number of bits to send; sampled on accept
- ready  output  1  high in IDLE only
- busy  output  1  high from accept until the cycle before `done`
- done  output  1  one-cycle pulse; `resp` valid from this cycle until the next accept
- resp  output  WIDTH  captured FSM outputs, bit k = response to pattern bit k; bits ≥ len are 0
- fsm_in  output  1  serial bit to the FSM
- fsm_rst_n  output  1  reset to the FSM, active-low
- fsm_out  input  1  FSM output (Moore)

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE; encoded in 3 bits.
- IDLE: ready=1, fsm_rst_n=1, fsm_in=0. If start=1, latch pattern, len, and clear resp and bit counter. Go to CLR, or go to DONE directly when len=0, leaving resp all-zero.
- len > WIDTH is clamped to WIDTH.
- CLR: fsm_rst_n=0 for exactly one cycle. Then go to RUN.
- RUN: fsm_in = pattern[cnt]; cnt increments each cycle. From the second RUN cycle on, capture resp[cnt-1] = fsm_out. After the cycle with cnt=len-1, go to DRAIN.
- DRAIN: fsm_in=0; capture resp[len-1] = fsm_out. Go to DONE.
- DONE: done=1 for one cycle, busy=0. Go to IDLE.
- start in any state other than IDLE is ignored, with no queueing.
- All outputs registered. Reset values: state IDLE, ready=0 while rst_n=0 and 1 after, busy=0, done=0, resp=0, fsm_in=0, fsm_rst_n=0.
- Reset mid-run aborts immediately. No done is issued, and resp returns to 0.

## Timing
- Accept on edge E0. CLR during cycle E0..E1. RUN occupies len cycles. DRAIN takes 1 cycle. done is high in the cycle after DRAIN.
- Accept-to-done latency = len+3 cycles for len≥1, and 1 cycle for len=0.
- fsm_out is sampled one cycle after the corresponding fsm_in bit, which matches the Moore output lag.
- Back-to-back operation: start may be asserted in the cycle ready returns. Minimum period = len+4 cycles.

## Configuration
- SERIAL_SEQ_COMPARE_EN defined:
  - Adds input `expect [WIDTH-1:0]`, latched on accept.
  - Adds output `mismatch` (1 bit), registered and reset to 0. It is set with `done` when (resp ^ expect) masked to len bits ≠ 0, and held until the next accept.
  - Adds output `err_cnt [7:0]`, which saturates at 255, increments on each mismatching run, and clears only on rst_n.
- Not defined: these ports and their logic are absent, and behaviour is otherwise identical.

## Structure
- Package `serial_seq_pkg`: state enum (IDLE, CLR, RUN, DRAIN, DONE), `SEQ_MAX_WIDTH`=32.
- One sub-module `serial_seq_cnt`: bit counter with load/enable and a `last` flag (cnt==len-1). It is shared between the shift and capture indexing.
- Capture the response with an index-addressed register, not a shift register, so that bits ≥ len stay 0.

## Test plan
- Reset: hold rst_n=0 for 3 cycles. Require ready=0, busy=0, done=0, resp=0, fsm_rst_n=0, fsm_in=0. After release, ready=1 next cycle.
- Directed run with the 4-state Moore FSM (a→b/c, out a0 b1 c1 d0): WIDTH=8, pattern=8'b0000_0101, len=4. Require fsm_in sequence 1,0,1,0, one fsm_rst_n low pulse, done at accept+7, resp=8'b0000_1011.
- pattern=8'b0000_0111, len=3 → resp=8'b0000_0001. Immediately follow with a back-to-back start in the ready cycle. The second run proceeds with no lost cycle.
- Edge lengths: len=0 gives done at accept+1 with resp=0 and no fsm_rst_n pulse. len=9 (clamped to 8) with pattern=8'hFF gives 8 RUN cycles and resp matching the FSM trace.
- Protocol: start held high throughout a run gives exactly one accept per IDLE visit. Reset asserted in the 3rd RUN cycle gives no done, resp=0, and ready after release.
- With SERIAL_SEQ_COMPARE_EN, expect=8'b0000_1011 on the directed run → mismatch=0. With expect=8'b0000_1111 → mismatch=1 and err_cnt=1.
